demux14_tdm: RTL

- Registered 1-to-4 demultiplexer. It is the distribution side of the team's 4-to-1 selector path.
- Takes one WIDTH-bit input stream and steers each valid beat into one of four held output channels.
- Channel choice comes from an internal round-robin slot counter (auto mode) or from the external select lines iS1/iS0 (manual mode).
- Sits after a time-multiplexed 4-channel link and rebuilds the four parallel nibble channels for downstream display/logic.

---
 rtl/demux14_tdm_if.sv | 18 +
 rtl/demux14_tdm.sv | 38 +++
 2 files changed

// File: rtl/demux14_tdm_if.sv
// demux14_tdm_if: input beat, select controls and held channel outputs of the 1-to-4 TDM demux.
interface demux14_tdm_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] iData;
  logic iValid;
  logic iAuto;
  logic iS1;
  logic iS0;
  logic iSync;
  logic [WIDTH-1:0] oC0;
  logic [WIDTH-1:0] oC1;
  logic [WIDTH-1:0] oC2;
  logic [WIDTH-1:0] oC3;
  logic [3:0] oStb;
  logic oFrame;
  logic [1:0] oSlot;
  modport master (output iData, iValid, iAuto, iS1, iS0, iSync, input oC0, oC1, oC2, oC3, oStb, oFrame, oSlot);
  modport slave (input iData, iValid, iAuto, iS1, iS0, iSync, output oC0, oC1, oC2, oC3, oStb, oFrame, oSlot);
endinterface

// File: rtl/demux14_tdm.sv
// demux14_tdm: registered 1-to-4 demux steering valid beats into held channels by round-robin slot or manual select.
module demux14_tdm #(parameter int WIDTH = 4) (
  input logic iClk,
  input logic iRst_n,
  demux14_tdm_if.slave bus
);
  logic [WIDTH-1:0] chan [4];
  logic [3:0] stb;
  logic frame;
  logic [1:0] slot;
  logic [1:0] effSlot;
  logic [1:0] sel;
  always_comb begin
    effSlot = bus.iSync ? 2'd0 : slot;
    sel = bus.iAuto ? effSlot : {bus.iS1, bus.iS0};
  end
  // the slot only advances on auto beats; otherwise it holds, except that sync clears it
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 4; i++) chan[i] <= '0;
      stb <= '0;
      frame <= 1'b0;
      slot <= 2'd0;
    end else begin
      if (bus.iValid) chan[sel] <= bus.iData;
      stb <= bus.iValid ? 4'b0001 << sel : 4'b0000;
      frame <= bus.iValid && bus.iAuto && effSlot == 2'd3;
      slot <= (bus.iValid && bus.iAuto) ? effSlot + 2'd1 : effSlot;
    end
  end
  assign bus.oC0 = chan[0];
  assign bus.oC1 = chan[1];
  assign bus.oC2 = chan[2];
  assign bus.oC3 = chan[3];
  assign bus.oStb = stb;
  assign bus.oFrame = frame;
  assign bus.oSlot = slot;
endmodule
